// File: rtl/lights_pkg.sv
// ---------------------------------------------------------------------------
// lights_pkg
// Shared definitions for the red/amber/green traffic-light interface.
// Used by the lights generator and by lights_monitor.
//   - RAG_* : lamp codes, packed as {red, amber, green}
//   - mon_state_t : lights_monitor FSM state encoding
//   - ERR_* : lights_monitor err_code values
//   - helper functions that describe the legal UK sequence
// ---------------------------------------------------------------------------
package lights_pkg;

  localparam logic [2:0] RAG_RED       = 3'b100;
  localparam logic [2:0] RAG_RED_AMBER = 3'b110;
  localparam logic [2:0] RAG_GREEN     = 3'b001;
  localparam logic [2:0] RAG_AMBER     = 3'b010;

  typedef enum logic [2:0] {
    UNSYNC  = 3'd0,
    S_RED   = 3'd1,
    S_RA    = 3'd2,
    S_GREEN = 3'd3,
    S_AMBER = 3'd4
  } mon_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CODE  = 2'd1;
  localparam logic [1:0] ERR_TRANS = 2'd2;
  localparam logic [1:0] ERR_DWELL = 2'd3;

  // True for the four codes that appear in the legal sequence.
  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == RAG_RED)   || (code == RAG_RED_AMBER) ||
           (code == RAG_GREEN) || (code == RAG_AMBER);
  endfunction

  // Lamp code a tracking state expects to see while holding.
  // UNSYNC has no code of its own; it maps to an illegal pattern.
  function automatic logic [2:0] state_code(input mon_state_t s);
    case (s)
      S_RED:   return RAG_RED;
      S_RA:    return RAG_RED_AMBER;
      S_GREEN: return RAG_GREEN;
      S_AMBER: return RAG_AMBER;
      default: return 3'b000;
    endcase
  endfunction

  // Successor of a tracking state in RED -> RA -> GREEN -> AMBER -> RED.
  function automatic mon_state_t succ_state(input mon_state_t s);
    case (s)
      S_RED:   return S_RA;
      S_RA:    return S_GREEN;
      S_GREEN: return S_AMBER;
      S_AMBER: return S_RED;
      default: return UNSYNC;
    endcase
  endfunction

  // Lamp code that represents a legal advance out of state s.
  function automatic logic [2:0] next_code(input mon_state_t s);
    return state_code(succ_state(s));
  endfunction

endpackage

// File: rtl/lights_dwell_timer.sv
// ---------------------------------------------------------------------------
// lights_dwell_timer
// Counts consecutive samples of the same legal lamp code. The count is set to
// 1 when the monitor enters a state and increments on each hold, saturating
// at MAX_DWELL. limit is high while the count equals MAX_DWELL, i.e. the next
// hold would exceed the allowed dwell.
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   load  : set count to 1 (state entry)
//   inc   : increment count (hold in the same state)
//   limit : count == MAX_DWELL
// ---------------------------------------------------------------------------
module lights_dwell_timer #(
  parameter int MAX_DWELL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic limit
);

  localparam int W = $clog2(MAX_DWELL + 1);
  localparam logic [W-1:0] DWELL_MAX = W'(MAX_DWELL);

  logic [W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (inc && (count != DWELL_MAX)) begin
      count <= count + W'(1);
    end
  end

  assign limit = (count == DWELL_MAX);

endmodule

// File: rtl/lights_monitor.sv
// ---------------------------------------------------------------------------
// lights_monitor
// Receive-side monitor for the three-wire traffic-light interface. Samples
// {red, amber, green} every clock, locks onto the UK sequence
// RED -> RED+AMBER -> GREEN -> AMBER -> RED, and reports go/stop, protocol
// errors and a count of completed sequences. All outputs are registered:
// a sample taken at edge k shows up on the outputs right after edge k.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   red/amber/green : lamp inputs from the generator
//   go       : synced and last sample was GREEN
//   stop     : inverse of go
//   synced   : monitor is locked to the sequence
//   seq_err  : one-cycle pulse on any detected error
//   err_code : last error (ERR_CODE / ERR_TRANS / ERR_DWELL), held
//   cycles   : completed sequences (AMBER -> RED advances), wraps
//
// Build option: define LIGHTS_MON_DWELL_EN to build the dwell timer and the
// dwell-timeout check (err_code 3). Without it, holds of any length are legal
// and MAX_DWELL is only range-checked.
// ---------------------------------------------------------------------------
module lights_monitor
  import lights_pkg::*;
#(
  parameter int MAX_DWELL = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       amber,
  input  logic       green,
  output logic       go,
  output logic       stop,
  output logic       synced,
  output logic       seq_err,
  output logic [1:0] err_code,
  output logic [7:0] cycles
);

  if ((MAX_DWELL < 1) || (MAX_DWELL > 255)) begin : g_param_check
    $error("lights_monitor: MAX_DWELL must be in 1..255");
  end

  logic [2:0] code;
  assign code = {red, amber, green};

  mon_state_t state_q, state_d;
  logic       err_d;
  logic [1:0] err_type_d;
  logic       cyc_inc_d;
  logic       go_d, synced_d;

`ifdef LIGHTS_MON_DWELL_EN
  logic dwell_load, dwell_inc, dwell_limit;

  lights_dwell_timer #(
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (dwell_load),
    .inc   (dwell_inc),
    .limit (dwell_limit)
  );
`endif

  // State and output registers. rst wins over every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNSYNC;
      go       <= 1'b0;
      stop     <= 1'b1;
      synced   <= 1'b0;
      seq_err  <= 1'b0;
      err_code <= ERR_NONE;
      cycles   <= 8'd0;
    end else begin
      state_q <= state_d;
      go      <= go_d;
      stop    <= ~go_d;
      synced  <= synced_d;
      seq_err <= err_d;
      if (err_d) begin
        err_code <= err_type_d;
      end
      if (cyc_inc_d) begin
        cycles <= cycles + 8'd1;
      end
    end
  end

  // Next-state logic. Error checks are evaluated in priority order:
  // illegal code, then illegal transition, then dwell timeout.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    err_d      = 1'b0;
    err_type_d = ERR_NONE;
    cyc_inc_d  = 1'b0;
`ifdef LIGHTS_MON_DWELL_EN
    dwell_load = 1'b0;
    dwell_inc  = 1'b0;
`endif

    if (state_q == UNSYNC) begin
      // Only a RED sample locks on; anything else is silently ignored.
      if (code == RAG_RED) begin
        state_d = S_RED;
`ifdef LIGHTS_MON_DWELL_EN
        dwell_load = 1'b1;
`endif
      end
    end else if (!is_legal_code(code)) begin
      state_d    = UNSYNC;
      err_d      = 1'b1;
      err_type_d = ERR_CODE;
    end else if (code == state_code(state_q)) begin
      // Hold in the current state.
`ifdef LIGHTS_MON_DWELL_EN
      if (dwell_limit) begin
        state_d    = UNSYNC;
        err_d      = 1'b1;
        err_type_d = ERR_DWELL;
      end else begin
        dwell_inc = 1'b1;
      end
`endif
    end else if (code == next_code(state_q)) begin
      state_d = succ_state(state_q);
      if (state_q == S_AMBER) begin
        cyc_inc_d = 1'b1;
      end
`ifdef LIGHTS_MON_DWELL_EN
      dwell_load = 1'b1;
`endif
    end else begin
      state_d    = UNSYNC;
      err_d      = 1'b1;
      err_type_d = ERR_TRANS;
    end
  end

  // Output decode from the next state; registered above so the outputs line
  // up with the state they describe.
  always_comb begin
    go_d     = (state_d == S_GREEN);
    synced_d = (state_d != UNSYNC);
  end

endmodule
